// File: rtl/uart_resp_framer_pkg.sv
// Shared constants, FSM encoding and frame byte selection for the UART response framer.
package uart_resp_framer_pkg;

  localparam int RESP_W    = 42;
  localparam int TYPE_BIT  = 41;
  localparam int ADDR_MSB  = 40;
  localparam int ADDR_LSB  = 32;
  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  localparam logic [7:0]       DEFAULT_HEADER = 8'hA5;
  localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Byte idx of the frame built from word; the last byte is the running checksum.
  function automatic logic [7:0] frame_byte(input logic [RESP_W-1:0] word,
                                            input logic [IDX_W-1:0]  idx,
                                            input logic [7:0]        header,
                                            input logic [7:0]        csum);
    logic [7:0] b;
    b = header;
    case (idx)
      3'd0:    b = header;
      3'd1:    b = {word[TYPE_BIT], 6'b000000, word[ADDR_MSB]};
      3'd2:    b = word[ADDR_LSB+7:ADDR_LSB];
      3'd3:    b = word[31:24];
      3'd4:    b = word[23:16];
      3'd5:    b = word[15:8];
      3'd6:    b = word[7:0];
      default: b = csum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_resp_framer_if.sv
// Memory-response input, UART byte handshake and status signals of the framer.
interface uart_resp_framer_if #(
  parameter int FIFO_DEPTH = 4
);
  import uart_resp_framer_pkg::*;

  logic                          resp_valid;
  logic [RESP_W-1:0]             resp_data;
  logic [7:0]                    tx_byte;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          busy;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output resp_valid, resp_data, tx_ready,
    input  tx_byte, tx_valid, busy, overflow, fifo_count
  );

  modport slave (
    input  resp_valid, resp_data, tx_ready,
    output tx_byte, tx_valid, busy, overflow, fifo_count
  );

endinterface

// File: rtl/uart_resp_framer_fifo.sv
// Synchronous FIFO; a push on a full FIFO is accepted only when a pop frees a slot the same cycle.
module resp_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_resp_framer.sv
// Buffers memory read responses and serializes each into an 8-byte checksummed UART frame.
// state   | meaning
// IDLE    | no frame in flight; pops the next response when the FIFO is non-empty
// SEND    | presenting frame byte idx on tx_byte until the transmitter takes it
module uart_resp_framer
  import uart_resp_framer_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER
) (
  input  logic               clk,
  input  logic               reset,
  uart_resp_framer_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [RESP_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        csum_q;
  logic [RESP_W-1:0] frame_q;
  logic [7:0]        tx_byte_q;
  logic              tx_valid_q;
  logic              overflow_q;

  logic              pop_d;
  logic              accept_d;
  logic [IDX_W-1:0]  idx_d;
  logic [7:0]        csum_d;
  logic [7:0]        next_byte_d;

  resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.resp_valid),
    .wdata_i (bus.resp_data),
    .pop_i   (pop_d),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop_d    = (state_q == ST_IDLE) & ~fifo_empty;
  assign accept_d = tx_valid_q & bus.tx_ready;
  assign idx_d    = idx_q + 1'b1;

  // tx_byte_q always holds B[idx], so it folds straight into the checksum.
  assign csum_d      = ((idx_q != '0) && (idx_q != LAST_IDX)) ? (csum_q ^ tx_byte_q) : csum_q;
  assign next_byte_d = frame_byte(frame_q, idx_d, HEADER_BYTE, csum_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      frame_q    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.resp_valid && fifo_full && !pop_d) overflow_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (pop_d) begin
            frame_q    <= fifo_rdata;
            idx_q      <= '0;
            csum_q     <= '0;
            tx_byte_q  <= HEADER_BYTE;
            tx_valid_q <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept_d) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              idx_q     <= idx_d;
              csum_q    <= csum_d;
              tx_byte_q <= next_byte_d;
            end
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = fifo_count;
  assign bus.busy       = (fifo_count != '0) | (state_q == ST_SEND);

endmodule

// File: tb/tb_uart_resp_framer.sv
// Scoreboard bench: stimulus queues hand-computed frame bytes, a negedge monitor checks the UART side.
module tb_uart_resp_framer;

  logic clk;
  logic reset;

  uart_resp_framer_if #(.FIFO_DEPTH(4)) bus ();

  uart_resp_framer #(.FIFO_DEPTH(4), .HEADER_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  logic       bp_mode     = 1'b0;
  logic       ready_level = 1'b0;
  int         bp_cnt      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes B0..B6 are plain field slices of the frame format; the checksum byte is hand-computed.
  task automatic expect_frame(input logic [41:0] w, input logic [7:0] csum);
    exp_q.push_back(8'hA5);
    exp_q.push_back({w[41], 6'b000000, w[40]});
    exp_q.push_back(w[39:32]);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(csum);
  endtask

  // Called at posedge+1; drives a one-cycle strobe.
  task automatic strobe(input logic [41:0] w, input logic [7:0] csum, input logic accepted);
    bus.resp_valid = 1'b1;
    bus.resp_data  = w;
    if (accepted) expect_frame(w, csum);
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < budget), 64'd1);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      bus.tx_ready = (bp_cnt % 3 == 0);
      bp_cnt++;
    end else begin
      bus.tx_ready = ready_level;
    end
  end

  logic       stalled = 1'b0;
  logic [7:0] held    = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(bus.tx_valid), 64'd1);
        chk("stall_byte", 64'(bus.tx_byte), 64'(held));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 64'(bus.tx_byte), 64'hFFFF);
        end else begin
          chk("tx_byte", 64'(bus.tx_byte), 64'(exp_q.pop_front()));
        end
        stalled = 1'b0;
      end else if (bus.tx_valid) begin
        stalled = 1'b1;
        held    = bus.tx_byte;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  localparam logic [41:0] T1 = {1'b0, 9'h005, 32'hDEADBEEF};
  localparam logic [41:0] T2 = {1'b1, 9'h1FF, 32'h12345678};
  localparam logic [41:0] V0 = {1'b0, 9'h010, 32'h01020304};
  localparam logic [41:0] V1 = {1'b1, 9'h120, 32'hF0F0F0F0};
  localparam logic [41:0] V2 = {1'b0, 9'h0FF, 32'h00000000};
  localparam logic [41:0] V3 = {1'b1, 9'h000, 32'hFFFFFFFF};
  localparam logic [41:0] V4 = {1'b0, 9'h1A5, 32'hA5A5A5A5};
  localparam logic [41:0] V5 = {1'b1, 9'h155, 32'h55555555};
  localparam logic [41:0] W0 = {1'b0, 9'h0AA, 32'h11223344};

  initial begin
    int n;
    reset          = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.tx_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_tx_byte", 64'(bus.tx_byte), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);

    // Single frame with latency check
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    strobe(T1, 8'h27, 1'b1);
    chk("lat_count_after_push", 64'(bus.fifo_count), 64'd1);
    chk("lat_valid_before_pop", 64'(bus.tx_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_after_pop", 64'(bus.tx_valid), 64'd1);
    chk("lat_first_byte", 64'(bus.tx_byte), 64'hA5);
    wait_idle("single", 100);
    chk("single_valid_low", 64'(bus.tx_valid), 64'd0);
    chk("single_busy_low", 64'(bus.busy), 64'd0);

    // Type bit and address MSB
    strobe(T2, 8'h76, 1'b1);
    wait_idle("type_addr", 100);

    // Backpressure, ready one cycle in three
    bp_mode = 1'b1;
    @(posedge clk);
    #1;
    strobe(T1, 8'h27, 1'b1);
    wait_idle("backpressure", 200);
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Overflow: first word goes to the frame, four fill the FIFO, the sixth is dropped
    ready_level = 1'b0;
    @(posedge clk);
    #1;
    strobe(V0, 8'h14, 1'b1);
    strobe(V1, 8'hA1, 1'b1);
    strobe(V2, 8'hFF, 1'b1);
    strobe(V3, 8'h80, 1'b1);
    strobe(V4, 8'hA4, 1'b1);
    strobe(V5, 8'hD4, 1'b0);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_count", 64'(bus.fifo_count), 64'd4);
    ready_level = 1'b1;
    wait_idle("overflow", 400);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    chk("ovf_count_drained", 64'(bus.fifo_count), 64'd0);

    // Push on full while IDLE pops in the same cycle
    do_reset();
    chk("reset_clears_ovf", 64'(bus.overflow), 64'd0);
    ready_level = 1'b0;
    @(posedge clk);
    #1;
    strobe(W0, 8'hEE, 1'b1);
    strobe(V1, 8'hA1, 1'b1);
    strobe(V2, 8'hFF, 1'b1);
    strobe(V3, 8'h80, 1'b1);
    strobe(V4, 8'hA4, 1'b1);
    chk("full_count", 64'(bus.fifo_count), 64'd4);
    chk("full_no_ovf", 64'(bus.overflow), 64'd0);
    ready_level = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.tx_valid && bus.tx_ready && bus.tx_byte == 8'hEE) && n < 200);
    chk("find_last_byte_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    strobe(V5, 8'hD4, 1'b1);
    chk("pushpop_no_ovf", 64'(bus.overflow), 64'd0);
    chk("pushpop_count", 64'(bus.fifo_count), 64'd4);
    wait_idle("pushpop", 600);

    // Reset mid-frame with one word still buffered
    strobe(T1, 8'h27, 1'b1);
    strobe(T2, 8'h76, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.tx_valid && bus.tx_ready && bus.tx_byte == 8'hDE) && n < 200);
    chk("find_b3_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_count", 64'(bus.fifo_count), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    strobe(T1, 8'h27, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_first_byte", 64'(bus.tx_byte), 64'hA5);
    wait_idle("post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_resp_framer.md
Name: uart_resp_framer

Overview:
Downstream of the data/instruction memory UART debug port. Accepts the 42-bit read-response word (type, address, data) pulsed by the memory on its tx-ready strobe, buffers it in a small FIFO, and serializes it into an 8-byte frame for the UART transmitter over a valid/ready byte handshake. Decouples single-cycle memory response pulses from the slow UART byte rate.

Parameters:
FIFO_DEPTH, 4, number of 42-bit response words buffered; power of two, >= 2
HEADER_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
resp_valid  input  1  one-cycle strobe from memory (data_mem_tx_data_ready)
resp_data  input  42  {mem_type[41], addr[40:32], data[31:0]} from memory uart_tx_data_out
tx_byte  output  8  byte to UART transmitter
tx_valid  output  1  tx_byte valid
tx_ready  input  1  transmitter accepts tx_byte this cycle
busy  output  1  FIFO non-empty or frame in progress
overflow  output  1  sticky: a response was dropped because FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (sync, rising clk with reset=1): FIFO pointers/count 0, state IDLE, byte index 0, checksum 0, tx_valid 0, tx_byte 0, busy 0, overflow 0. Reset mid-frame aborts the frame; no further bytes of it are sent.
- Frame (8 bytes, in order): B0=HEADER_BYTE; B1={mem_type,6'b0,addr[8]}; B2=addr[7:0]; B3..B6=data[31:24],[23:16],[15:8],[7:0]; B7=XOR of B1..B6 (header excluded).
- FIFO push: on resp_valid, if not full -> write at wr_ptr, wr_ptr wraps mod FIFO_DEPTH. If full and no pop this cycle -> word dropped, overflow <= 1 (sticky until reset). If full and a pop occurs the same cycle -> push accepted, no overflow.
- FSM states: IDLE, SEND.
  - IDLE: tx_valid=0. If FIFO non-empty: pop head into 42-bit frame register, idx<=0, checksum<=0, -> SEND.
  - SEND: tx_valid=1, tx_byte=B[idx] (B7 driven from running checksum). On tx_valid&tx_ready: if 1<=idx<=6 checksum<=checksum^B[idx]; if idx==7 -> IDLE, else idx<=idx+1. Without tx_ready, tx_byte/tx_valid hold stable (no change while stalled).
- Latency: resp_valid at edge N (FIFO empty, IDLE) -> popped at edge N+1 -> tx_valid=1 with B0 after edge N+1. One idle cycle between consecutive frames (SEND->IDLE->SEND).
- tx_ready while tx_valid=0 is ignored.
- busy = (fifo_count!=0) | (state==SEND).
- Frame register is independent of FIFO storage; pushes during SEND never corrupt the frame in flight.

Decomposition:
- Shared package: RESP_W=42, field positions (TYPE_BIT=41, ADDR_MSB=40, ADDR_LSB=32), FRAME_LEN=8, default HEADER_BYTE, FSM state encoding.
- One sub-module natural: resp_fifo (parameterized width/depth synchronous FIFO with push/pop/full/empty/count, sync active-high reset); framer FSM in top.

Test Plan:
- Single frame: resp_data={1'b0,9'h005,32'hDEADBEEF} strobe, tx_ready=1 always -> bytes A5 00 05 DE AD BE EF 27, tx_valid low after B7, busy low one cycle later.
- Type/addr MSB: {1'b1,9'h1FF,32'h12345678} -> A5 81 FF 12 34 56 78 76.
- Backpressure: same as first test, tx_ready toggled 1-of-3 cycles -> identical byte sequence, tx_byte stable while tx_valid&!tx_ready.
- Overflow: tx_ready=0, 6 strobes with FIFO_DEPTH=4 -> first popped into frame, 4 buffered, 6th dropped, overflow=1, fifo_count=4; release tx_ready -> exactly 5 frames emitted, overflow stays 1.
- Push on full with pop: FIFO full, strobe on the cycle IDLE pops -> accepted, overflow stays 0, fifo_count stays 4.
- Reset mid-frame: assert reset after B3 accepted -> next cycle tx_valid=0, busy=0, fifo_count=0; new strobe afterwards yields a clean frame starting A5.
